// File: rtl/counter_8bit.sv
// Free-running binary up-counter used as a cycle count / timebase.
// An asynchronous active-low reset loads RESET_VALUE; otherwise the counter adds STEP on every rising clk edge.
`timescale 1ns/100ps
module counter_8bit #(
  parameter int WIDTH       = 8,
  parameter int STEP        = 1,
  parameter int RESET_VALUE = 0
) (
  output logic [WIDTH-1:0] count,
  input  logic             clk,
  input  logic             reset
);

  // Truncating to WIDTH bits applies the modulo 2^WIDTH to both parameters.
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q;

  // The carry out of the top bit is dropped, so the counter wraps with no flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RESET_W;
    end else begin
      count_q <= count_q + STEP_W;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_counter_8bit.sv
// Self-checking bench for counter_8bit: a vector table, a running model for long runs,
// and hand-written sequences for asynchronous reset, a stopped clock and an edge-coincident release.
`timescale 1ns/100ps
module tb_counter_8bit;

  typedef struct {
    logic       rst;
    logic [7:0] exp;
  } vec_t;

  logic       clk;
  logic       clk_en;
  logic       reset;
  logic [7:0] count;

  logic [7:0] exp_q[$];
  int         checks;
  int         errors;

  counter_8bit dut (
    .count (count),
    .clk   (clk),
    .reset (reset)
  );

  // 2 ns clock that can be frozen at 0 by clearing clk_en right after a falling edge.
  initial begin
    clk = 1'b0;
    forever begin
      #1;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic check_out(input string name);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected value queued, count=%h", name, count);
    end else begin
      e = exp_q.pop_front();
      if (count !== e) begin
        errors++;
        $display("FAIL %s: count=%h expected=%h at %0t", name, count, e, $time);
      end
    end
  endtask

  task automatic check_now(input string name, input logic [7:0] e);
    exp_q.push_back(e);
    check_out(name);
  endtask

  // Drive reset between edges, then sample half a period after the next rising edge.
  task automatic drive_cycle(input logic rst, input logic [7:0] e, input string name);
    @(negedge clk);
    reset = rst;
    exp_q.push_back(e);
    @(posedge clk);
    #0.5;
    check_out(name);
  endtask

  vec_t       vecs[12];
  logic [7:0] m;
  bit         seen_fe, seen_ff, seen_wrap;

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b1;
    reset  = 1'b0;
    #0.5;
    check_now("reset_state", 8'h00);

    // Power-up hold, release and count, async reset, second release.
    vecs[0]  = '{1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00};
    vecs[3]  = '{1'b1, 8'h01};
    vecs[4]  = '{1'b1, 8'h02};
    vecs[5]  = '{1'b1, 8'h03};
    vecs[6]  = '{1'b1, 8'h04};
    vecs[7]  = '{1'b1, 8'h05};
    vecs[8]  = '{1'b0, 8'h00};
    vecs[9]  = '{1'b0, 8'h00};
    vecs[10] = '{1'b1, 8'h01};
    vecs[11] = '{1'b1, 8'h02};
    for (int i = 0; i < 12; i++) begin
      drive_cycle(vecs[i].rst, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Wrap: 260 edges after release against a modulo-256 model.
    drive_cycle(1'b0, 8'h00, "wrap_reset");
    m = 8'h00;
    seen_fe = 0; seen_ff = 0; seen_wrap = 0;
    for (int i = 0; i < 260; i++) begin
      m = m + 8'h01;
      drive_cycle(1'b1, m, "wrap_run");
      if (count == 8'hFE) seen_fe = 1;
      if (count == 8'hFF && seen_fe) seen_ff = 1;
      if (count == 8'h00 && seen_ff) seen_wrap = 1;
    end
    checks++;
    if (!(seen_fe && seen_ff && seen_wrap)) begin
      errors++;
      $display("FAIL wrap_seen: fe=%0d ff=%0d wrap=%0d expected all 1", seen_fe, seen_ff, seen_wrap);
    end

    // Asynchronous reset at count 0x37, applied between edges.
    drive_cycle(1'b0, 8'h00, "mid_pre_reset");
    m = 8'h00;
    while (m != 8'h37) begin
      m = m + 8'h01;
      drive_cycle(1'b1, m, "mid_count");
    end
    @(negedge clk);
    reset = 1'b0;
    #0.2;
    check_now("mid_async_clear", 8'h00);
    drive_cycle(1'b0, 8'h00, "mid_hold0");
    drive_cycle(1'b0, 8'h00, "mid_hold1");
    drive_cycle(1'b1, 8'h01, "mid_release");

    // Release coinciding with a rising edge: the edge still sees reset low.
    drive_cycle(1'b0, 8'h00, "coinc_reset");
    @(posedge clk);
    reset <= 1'b1;
    #0.5;
    check_now("coinc_edge", 8'h00);
    drive_cycle(1'b1, 8'h01, "coinc_next");
    drive_cycle(1'b1, 8'h02, "coinc_next2");

    // Reset with the clock stopped at 0 (and briefly X while reset is low).
    @(negedge clk);
    clk_en = 1'b0;
    #1;
    reset = 1'b0;
    #0.2;
    check_now("noclk_clear", 8'h00);
    clk = 1'bx;
    #1;
    check_now("noclk_x", 8'h00);
    clk = 1'b0;
    #2.8;
    reset = 1'b1;
    #1;
    check_now("noclk_after_release", 8'h00);
    #2;
    check_now("noclk_still0", 8'h00);
    clk_en = 1'b1;
    @(posedge clk);
    #0.5;
    check_now("noclk_first_edge", 8'h01);
    drive_cycle(1'b1, 8'h02, "noclk_second_edge");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop against a stuck run.
  initial begin
    #20000;
    $display("FAIL timeout: run exceeded 20000 ns");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
